adiabatic_pclk_sequencer: RTL and testbench

- Digital controller that generates the stepwise-charged four-phase power clocks driving the adiabatic gate pipeline: inverters, buffers and control-unit logic whose supply rails are clkpos/clkneg.
- Each phase cycles ramp-up, hold, ramp-down and wait. Adjacent phases lag by one quarter.
- Levels are multi-bit DAC codes for the stepwise charger banks, not logic values.
- Provides start/stop sequencing with graceful energy-recovering drain.

---
 rtl/adiabatic_pclk_sequencer.sv | 155 +++++++++++++++
 tb/tb_adiabatic_pclk_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adiabatic_pclk_sequencer.sv
// Four-phase stepwise power-clock sequencer for adiabatic logic rails.
// Phase i lags phase i-1 by one quarter; stop drains charge back before returning to idle.
module adiabatic_pclk_sequencer #(
  parameter int unsigned RAMP_STEPS = 4,
  parameter int unsigned LVL_W      = $clog2(RAMP_STEPS + 1),
  parameter int unsigned PCNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  output logic [4*LVL_W-1:0]   pos_lvl,
  output logic [4*LVL_W-1:0]   neg_lvl,
  output logic [1:0]           quarter,
  output logic [LVL_W-1:0]     step,
  output logic                 running,
  output logic                 busy,
  output logic [PCNT_W-1:0]    period_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [LVL_W-1:0] LastStep = LVL_W'(RAMP_STEPS - 1);
  localparam logic [LVL_W-1:0] FullLvl  = LVL_W'(RAMP_STEPS);

  state_e              state_q, state_d;
  logic [1:0]          quarter_q, quarter_d;
  logic [LVL_W-1:0]    step_q, step_d;
  logic [PCNT_W-1:0]   period_q, period_d;
  logic                stop_pend_q, stop_pend_d;
  logic                drain_half_q, drain_half_d;
  logic [3:0]          en_q, en_d;
  logic [4*LVL_W-1:0]  pos_q, pos_d, neg_q, neg_d;
  logic                running_q, running_d, busy_q, busy_d;
  logic                wrap;
  logic [1:0]          r;
  logic [LVL_W-1:0]    lvl;

  assign wrap = (step_q == LastStep);

  always_comb begin
    state_d      = state_q;
    quarter_d    = quarter_q;
    step_d       = step_q;
    period_d     = period_q;
    stop_pend_d  = stop_pend_q;
    drain_half_d = drain_half_q;

    // Counters advance identically in RUN and DRAIN.
    if (state_q != StIdle) begin
      step_d = wrap ? '0 : step_q + LVL_W'(1);
      if (wrap) begin
        quarter_d = quarter_q + 2'd1;
        if (quarter_q == 2'd3) period_d = period_q + PCNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d   = StRun;
          quarter_d = '0;
          step_d    = '0;
        end
      end
      StRun: begin
        if (stop) stop_pend_d = 1'b1;
        if (wrap && (stop_pend_q || stop)) begin
          state_d      = StDrain;
          stop_pend_d  = 1'b0;
          drain_half_d = 1'b0;
        end
      end
      StDrain: begin
        if (wrap) begin
          if (drain_half_q) begin
            state_d      = StIdle;
            quarter_d    = '0;
            step_d       = '0;
            drain_half_d = 1'b0;
          end else begin
            drain_half_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A phase only drives its rail after it has started a ramp-up, so no level ever jumps;
  // in DRAIN a phase reaching ramp-up is inhibited for good.
  always_comb begin
    en_d  = '0;
    pos_d = '0;
    neg_d = '0;
    r     = '0;
    lvl   = '0;
    for (int i = 0; i < 4; i++) begin
      r = quarter_d - 2'(i);
      unique case (state_d)
        StRun:   en_d[i] = en_q[i] | (r == 2'd0);
        StDrain: en_d[i] = en_q[i] & (r != 2'd0);
        default: en_d[i] = 1'b0;
      endcase
      unique case (r)
        2'd0:    lvl = step_d + LVL_W'(1);
        2'd1:    lvl = FullLvl;
        2'd2:    lvl = LastStep - step_d;
        default: lvl = '0;
      endcase
      if (!en_d[i]) lvl = '0;
      pos_d[i*LVL_W +: LVL_W] = lvl;
      neg_d[i*LVL_W +: LVL_W] = FullLvl - lvl;
    end
    running_d = (state_d == StRun);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      quarter_q    <= '0;
      step_q       <= '0;
      period_q     <= '0;
      stop_pend_q  <= 1'b0;
      drain_half_q <= 1'b0;
      en_q         <= '0;
      pos_q        <= '0;
      neg_q        <= {4{FullLvl}};
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      quarter_q    <= quarter_d;
      step_q       <= step_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      drain_half_q <= drain_half_d;
      en_q         <= en_d;
      pos_q        <= pos_d;
      neg_q        <= neg_d;
      running_q    <= running_d;
      busy_q       <= busy_d;
    end
  end

  assign pos_lvl    = pos_q;
  assign neg_lvl    = neg_q;
  assign quarter    = quarter_q;
  assign step       = step_q;
  assign running    = running_q;
  assign busy       = busy_q;
  assign period_cnt = period_q;

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Directed bench for adiabatic_pclk_sequencer: RAMP_STEPS=4 main instance plus a
// PCNT_W=2 instance for counter wrap and level-slew checks.
module tb_adiabatic_pclk_sequencer;

  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst, start, stop, start2, stop2;
  logic [4*LW-1:0] pos, neg, pos2, neg2;
  logic [1:0] quarter, quarter2;
  logic [LW-1:0] step, step2;
  logic running, busy, running2, busy2;
  logic [15:0] pcnt;
  logic [1:0] pcnt2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  adiabatic_pclk_sequencer #(.RAMP_STEPS(4), .PCNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pos_lvl(pos), .neg_lvl(neg), .quarter(quarter), .step(step),
    .running(running), .busy(busy), .period_cnt(pcnt)
  );

  adiabatic_pclk_sequencer #(.RAMP_STEPS(4), .PCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .pos_lvl(pos2), .neg_lvl(neg2), .quarter(quarter2), .step(step2),
    .running(running2), .busy(busy2), .period_cnt(pcnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [LW-1:0] ph(input logic [4*LW-1:0] v, input int i);
    return v[i*LW +: LW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input logic [1:0] q, input logic [LW-1:0] s);
    bit found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      if (quarter == q && step == s) found = 1;
      else tick();
    end
    if (!found) check("wait_pos_timeout", 0, 1);
  endtask

  logic [LW-1:0] exp_run0 [16];
  logic [LW-1:0] exp_dr_a [8];
  logic [LW-1:0] exp_dr_b [8];
  logic [4*LW-1:0] prev;
  int viol;

  initial begin
    exp_run0 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
                 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_dr_a = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_dr_b = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    rst = 1; start = 0; stop = 0; start2 = 0; stop2 = 0;
    tick(); tick();
    rst = 0;

    // Reset state
    check("rst_pos", pos, 0);
    check("rst_neg", neg, 12'h924);
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_pcnt", pcnt, 0);
    check("rst_qs", {quarter, step}, 0);

    // Full first period from start
    start = 1; tick(); start = 0;
    check("run_t1_qs", {quarter, step}, 0);
    check("run_t1_running", running, 1);
    check("run_t1_neg0", ph(neg, 0), 3);
    check("run_t1_pos", pos, 12'h001);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      check($sformatf("run_ph0_c%0d", c), ph(pos, 0), exp_run0[c-1]);
      if (c == 5) check("run_ph1_t5", ph(pos, 1), 1);
      if (c == 2) begin start = 1; end
      if (c == 3) begin
        start = 0;
        check("run_start_ignored_step", step, 2);
      end
    end
    check("run_pcnt_t16", pcnt, 0);
    tick();
    check("run_pcnt_t17", pcnt, 1);

    // Stop at quarter 2 step 1 -> drain from quarter 3
    wait_pos(2, 1);
    stop = 1; tick(); stop = 0;
    check("stop_pend_running", running, 1);
    tick();
    check("stop_pend_q2s3", {quarter, step}, {2'd2, 3'd3});
    tick();
    for (int d = 0; d < 8; d++) begin
      if (d > 0) tick();
      check($sformatf("drA_busy_d%0d", d), {running, busy}, 2'b01);
      check($sformatf("drA_ph0_d%0d", d), ph(pos, 0), 0);
      check($sformatf("drA_ph1_d%0d", d), ph(pos, 1), exp_dr_b[d]);
      check($sformatf("drA_ph2_d%0d", d), ph(pos, 2), exp_dr_a[d]);
      check($sformatf("drA_ph3_d%0d", d), ph(pos, 3), 0);
      start = (d == 2);
      stop  = (d == 3);
    end
    start = 0; stop = 0;
    tick();
    check("drA_idle_busy", busy, 0);
    check("drA_idle_pos", pos, 0);
    check("drA_idle_neg", neg, 12'h924);
    check("drA_idle_qs", {quarter, step}, 0);
    check("drA_pcnt_kept", pcnt, 2);

    // start+stop together and stop alone in IDLE
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("idle_both_busy", busy, 0);
    check("idle_both_pos", pos, 0);
    stop = 1; tick(); stop = 0;
    check("idle_stop_busy", busy, 0);

    // Stop on last step of quarter 1 -> drain begins next cycle
    start = 1; tick(); start = 0;
    wait_pos(1, 3);
    stop = 1; tick(); stop = 0;
    check("drB_qs", {quarter, step}, {2'd2, 3'd0});
    for (int d = 0; d < 8; d++) begin
      if (d > 0) tick();
      check($sformatf("drB_busy_d%0d", d), {running, busy}, 2'b01);
      check($sformatf("drB_ph0_d%0d", d), ph(pos, 0), exp_dr_b[d]);
      check($sformatf("drB_ph1_d%0d", d), ph(pos, 1), exp_dr_a[d]);
      check($sformatf("drB_ph2_d%0d", d), ph(pos, 2), 0);
      check($sformatf("drB_ph3_d%0d", d), ph(pos, 3), 0);
    end
    tick();
    check("drB_idle_busy", busy, 0);
    check("drB_idle_pos", pos, 0);

    // Reset mid-hold
    start = 1; tick(); start = 0;
    tick(); tick(); tick(); tick();
    check("mid_hold_ph0", ph(pos, 0), 4);
    rst = 1; tick(); rst = 0;
    check("mid_rst_pos", pos, 0);
    check("mid_rst_neg", neg, 12'h924);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pcnt", pcnt, 0);
    check("mid_rst_qs", {quarter, step}, 0);

    // PCNT_W=2: five periods, period_cnt wrap and slew limit
    viol = 0;
    prev = '0;
    start2 = 1; tick(); start2 = 0;
    for (int c = 1; c <= 81; c++) begin
      if (c > 1) tick();
      for (int i = 0; i < 4; i++) begin
        int a, b;
        a = ph(pos2, i);
        b = ph(prev, i);
        if (a - b > 1 || b - a > 1) viol++;
      end
      prev = pos2;
      if (c > 1 && (c - 1) % 16 == 0)
        check($sformatf("p2_pcnt_k%0d", (c - 1) / 16), pcnt2, ((c - 1) / 16) % 4);
    end
    check("p2_slew_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
